rf_multiport: RTL and testbench
===============================

RF_MULTIPORT -- requirements
Module: rf_multiport

Interface
REQ-001 Parameter W, default 32, data width in bits.
REQ-002 Parameter AW, default 5, address width; depth D = 2**AW.
REQ-003 Parameter NR, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, 1 = register 0 hard-wired to zero.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clock  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 wren  in  1  write request this cycle.
REQ-009 wraddress  in  AW  write address.
REQ-010 data  in  W  write data.
REQ-011 rdaddress  in  NR*AW  packed read addresses; port i = bits [i*AW +: AW].
REQ-012 rd_clk_cls  in  1  high = hold all registered read addresses (pipeline stall).
REQ-013 sb_set  in  1  mark register sb_addr pending (long-latency load issued).
REQ-014 sb_addr  in  AW  scoreboard set address.
REQ-015 q  out  NR*W  packed read data; port i = bits [i*W +: W].
REQ-016 busy  out  NR  per port: registered read address is pending.

Function
REQ-017 Every edge, read-address registers SHALL load rdaddress when rd_clk_cls=0 and hold otherwise.
REQ-018 Every edge, write-stage registers r_data, r_wraddress, r_wren SHALL load data, wraddress, and (wren AND NOT (ZERO_REG AND wraddress==0)); rd_clk_cls has no effect on them.
REQ-019 At each edge with r_wren=1, the bank entry r_wraddress SHALL be written with r_data (one-cycle write pipeline).
REQ-020 q port i, combinational from registers: 0 if ZERO_REG and address 0; else r_data if r_wren and r_wraddress equals the port address; else bank entry.
REQ-021 A write presented in the same cycle as a read address to the same register SHALL appear on q after that same edge (zero-cycle RAW via forwarding).
REQ-022 A held address (rd_clk_cls=1) SHALL still see forwarding and bank updates; q reflects newest data.
REQ-023 Scoreboard: D busy bits; sb_set sets bit sb_addr at the edge; a captured write (wren=1, REQ-018 gating) clears bit wraddress at the same edge.
REQ-024 Simultaneous set and clear of the same address: set wins.
REQ-025 With ZERO_REG=1, sb_set to address 0 SHALL be ignored; bit 0 stays 0.
REQ-026 busy[i] SHALL equal the scoreboard bit of port i's registered address (combinational from registers).
REQ-027 Multiple ports with equal addresses SHALL return identical q and busy.

Reset
REQ-028 On rst=1 at an edge: read-address registers, r_wraddress, r_data = 0; r_wren = 0; all busy bits = 0.
REQ-029 After reset q = 0 (ZERO_REG=1) and busy = 0; bank contents are not reset.
REQ-030 rst overrides wren, sb_set and rd_clk_cls in the same cycle; a write presented with rst is lost.

Structure
REQ-031 Package rf_pkg SHALL hold parameter defaults and the maximum NR constant.
REQ-032 Sub-module rf_read_port (address register, forwarding mux, busy select) SHALL be instantiated NR times via generate.
REQ-033 Bank is a plain register array; no vendor RAM macro.

Verification
REQ-034 Reset, write 0x1234_5678 to r3, read r3 on port0 in the same cycle -> q0=0x1234_5678 after that edge; still so two cycles later.
REQ-035 Write 0xFFFF_FFFF to r0 -> every port reading r0 returns 0; busy=0.
REQ-036 Port1 addr r7, rd_clk_cls=1, present rdaddress r9, write 0xA5 to r7 -> q1=0xA5, r9 not selected.
REQ-037 sb_set r5, then port0 reads r5 -> busy[0]=1; write 0x42 to r5 -> busy[0]=0 and q0=0x42 after the same edge.
REQ-038 Same cycle sb_set r6 and write r6 -> r6 busy afterwards; assert rst with wren to r2 -> r2 unchanged, all busy=0.
REQ-039 NR=4, AW=3, W=16 build: all ports read r4 after writing 0xBEEF -> four identical q values.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the multi-ported register file.
//
// Contents:
//   RF_W_DEFAULT        default data width in bits
//   RF_AW_DEFAULT       default address width (depth = 2**AW)
//   RF_NR_DEFAULT       default number of read ports
//   RF_ZERO_REG_DEFAULT default for hard-wiring register 0 to zero
//   RF_NR_MAX           largest supported number of read ports
package rf_pkg;

    localparam int RF_W_DEFAULT        = 32;
    localparam int RF_AW_DEFAULT       = 5;
    localparam int RF_NR_DEFAULT       = 2;
    localparam int RF_ZERO_REG_DEFAULT = 1;
    localparam int RF_NR_MAX           = 4;

endpackage

// File: rtl/rf_read_port.sv
// One read port of the register file: a stallable read-address register,
// the write-forwarding mux and the scoreboard (busy) bit select.
//
// Ports:
//   clock          rising-edge clock
//   rst            synchronous active-high reset (clears the address register)
//   rd_clk_cls_i   high = hold the registered read address
//   rdaddress_i    read address to capture when not held
//   r_wren_i       write stage valid (write lands in the bank at the next edge)
//   r_wraddress_i  write stage address
//   r_data_i       write stage data
//   bank_i         whole register bank, flattened
//   sb_i           whole scoreboard, one bit per register
//   q_o            read data for the registered address
//   busy_o         scoreboard bit for the registered address
module rf_read_port #(
    parameter int W        = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic                          rd_clk_cls_i,
    input  logic [AW-1:0]                 rdaddress_i,
    input  logic                          r_wren_i,
    input  logic [AW-1:0]                 r_wraddress_i,
    input  logic [W-1:0]                  r_data_i,
    input  logic [(1<<AW)-1:0][W-1:0]     bank_i,
    input  logic [(1<<AW)-1:0]            sb_i,
    output logic [W-1:0]                  q_o,
    output logic                          busy_o
);

    logic [AW-1:0] raddr_q;
    logic [AW-1:0] raddr_d;

    always_comb begin
        raddr_d = rd_clk_cls_i ? raddr_q : rdaddress_i;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            raddr_q <= '0;
        end else begin
            raddr_q <= raddr_d;
        end
    end

    // The write stage holds data that reaches the bank only at the next
    // edge; forwarding it here gives zero-cycle read-after-write, and it also
    // applies to a held address so a stalled reader always sees newest data.
    always_comb begin
        q_o = bank_i[raddr_q];
        if (r_wren_i && (r_wraddress_i == raddr_q)) begin
            q_o = r_data_i;
        end
        if ((ZERO_REG != 0) && (raddr_q == '0)) begin
            q_o = '0;
        end
        busy_o = sb_i[raddr_q];
    end

endmodule

// File: rtl/rf_multiport.sv
// Multi-read-port register file with a one-cycle write pipeline, read-after-
// write forwarding, stallable read addresses and a per-register pending
// (scoreboard) bit for long-latency loads.
//
// Ports:
//   clock       rising-edge clock for all state
//   rst         synchronous active-high reset
//   wren        write request this cycle
//   wraddress   write address
//   data        write data
//   rdaddress   packed read addresses, port i = [i*AW +: AW]
//   rd_clk_cls  high = hold all registered read addresses
//   sb_set      mark register sb_addr pending
//   sb_addr     scoreboard set address
//   q           packed read data, port i = [i*W +: W]
//   busy        per port: registered read address is pending
module rf_multiport
    import rf_pkg::*;
#(
    parameter int W        = RF_W_DEFAULT,
    parameter int AW       = RF_AW_DEFAULT,
    parameter int NR       = RF_NR_DEFAULT,
    parameter int ZERO_REG = RF_ZERO_REG_DEFAULT
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              wren,
    input  logic [AW-1:0]     wraddress,
    input  logic [W-1:0]      data,
    input  logic [NR*AW-1:0]  rdaddress,
    input  logic              rd_clk_cls,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    output logic [NR*W-1:0]   q,
    output logic [NR-1:0]     busy
);

    localparam int D = 1 << AW;

    if ((NR < 1) || (NR > RF_NR_MAX)) begin : g_bad_nr
        $error("rf_multiport: NR out of range");
    end

    logic [W-1:0]        r_data_q;
    logic [W-1:0]        r_data_d;
    logic [AW-1:0]       r_wraddress_q;
    logic [AW-1:0]       r_wraddress_d;
    logic                r_wren_q;
    logic                r_wren_d;
    logic [D-1:0][W-1:0] bank_q;
    logic [D-1:0]        sb_q;
    logic [D-1:0]        sb_d;
    logic                wr_capture;

    // Writes to the hard-wired zero register are dropped at capture so they
    // neither touch the bank nor disturb the scoreboard.
    always_comb begin
        wr_capture    = wren && !((ZERO_REG != 0) && (wraddress == '0));
        r_data_d      = data;
        r_wraddress_d = wraddress;
        r_wren_d      = wr_capture;
    end

    // Clear on a captured write first, then set, so a same-cycle set of the
    // same register wins (the new load is still outstanding).
    always_comb begin
        sb_d = sb_q;
        if (wr_capture) begin
            sb_d[wraddress] = 1'b0;
        end
        if (sb_set && !((ZERO_REG != 0) && (sb_addr == '0))) begin
            sb_d[sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_data_q      <= '0;
            r_wraddress_q <= '0;
            r_wren_q      <= 1'b0;
            sb_q          <= '0;
        end else begin
            r_data_q      <= r_data_d;
            r_wraddress_q <= r_wraddress_d;
            r_wren_q      <= r_wren_d;
            sb_q          <= sb_d;
        end
    end

    // Bank is not reset; a write already in the write stage still retires.
    always_ff @(posedge clock) begin
        if (r_wren_q) begin
            bank_q[r_wraddress_q] <= r_data_q;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_port
        rf_read_port #(
            .W        (W),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .clock         (clock),
            .rst           (rst),
            .rd_clk_cls_i  (rd_clk_cls),
            .rdaddress_i   (rdaddress[i*AW +: AW]),
            .r_wren_i      (r_wren_q),
            .r_wraddress_i (r_wraddress_q),
            .r_data_i      (r_data_q),
            .bank_i        (bank_q),
            .sb_i          (sb_q),
            .q_o           (q[i*W +: W]),
            .busy_o        (busy[i])
        );
    end

endmodule

// File: tb/tb_rf_multiport.sv
module tb_rf_multiport;

    // clock / reset
    logic clock = 1'b0;
    always #5 clock = ~clock;

    // main instance: W=32, AW=5, NR=2, ZERO_REG=1
    logic        rst = 1'b1;
    logic        wren = 1'b0;
    logic [4:0]  wraddress = '0;
    logic [31:0] data = '0;
    logic [9:0]  rdaddress = '0;
    logic        rd_clk_cls = 1'b0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_addr = '0;
    logic [63:0] q;
    logic [1:0]  busy;

    // wide instance: W=16, AW=3, NR=4
    logic        w_rst = 1'b1;
    logic        w_wren = 1'b0;
    logic [2:0]  w_wraddress = '0;
    logic [15:0] w_data = '0;
    logic [11:0] w_rdaddress = '0;
    logic        w_rd_clk_cls = 1'b0;
    logic        w_sb_set = 1'b0;
    logic [2:0]  w_sb_addr = '0;
    logic [63:0] w_q;
    logic [3:0]  w_busy;

    rf_multiport u_dut (
        .clock      (clock),
        .rst        (rst),
        .wren       (wren),
        .wraddress  (wraddress),
        .data       (data),
        .rdaddress  (rdaddress),
        .rd_clk_cls (rd_clk_cls),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .q          (q),
        .busy       (busy)
    );

    rf_multiport #(.W(16), .AW(3), .NR(4), .ZERO_REG(1)) u_wide (
        .clock      (clock),
        .rst        (w_rst),
        .wren       (w_wren),
        .wraddress  (w_wraddress),
        .data       (w_data),
        .rdaddress  (w_rdaddress),
        .rd_clk_cls (w_rd_clk_cls),
        .sb_set     (w_sb_set),
        .sb_addr    (w_sb_addr),
        .q          (w_q),
        .busy       (w_busy)
    );

    int errors = 0;
    int checks = 0;

    // reference model: architectural register contents, pending set,
    // and the address each read port is currently looking at
    logic [31:0] m_mem   [32];
    bit          m_known [32];
    bit          m_busy  [32];
    logic [4:0]  m_addr  [2];

    // Architectural effect of one clock edge given the current inputs.
    task automatic model_edge();
        if (rst) begin
            for (int p = 0; p < 2; p++) m_addr[p] = '0;
            for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        end else begin
            if (!rd_clk_cls) begin
                for (int p = 0; p < 2; p++) m_addr[p] = rdaddress[p*5 +: 5];
            end
            if (wren && (wraddress != 5'd0)) begin
                m_mem[wraddress]   = data;
                m_known[wraddress] = 1'b1;
                m_busy[wraddress]  = 1'b0;
            end
            if (sb_set && (sb_addr != 5'd0)) m_busy[sb_addr] = 1'b1;
        end
    endtask

    // driver: apply model, advance one edge, return at the falling edge
    task automatic tick();
        model_edge();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        rst = 1'b0; wren = 1'b0; sb_set = 1'b0; rd_clk_cls = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wren = 1'b1; wraddress = 5'd9; data = 32'hDEAD_0009;
        sb_set = 1'b1; sb_addr = 5'd4; rd_clk_cls = 1'b1;
        rdaddress = {5'd4, 5'd9};
        tick();
        checks++;
        if (q !== 64'd0) begin
            errors++; $display("FAIL reset_q: got %h expected %h", q, 64'd0);
        end
        checks++;
        if (busy !== 2'b00) begin
            errors++; $display("FAIL reset_busy: got %b expected %b", busy, 2'b00);
        end
        idle();
    endtask

    task automatic test_raw();
        wren = 1'b1; wraddress = 5'd3; data = 32'h1234_5678;
        rdaddress = {5'd0, 5'd3};
        tick();
        checks++;
        if (q[31:0] !== 32'h1234_5678) begin
            errors++; $display("FAIL raw_same_edge: got %h expected %h", q[31:0], 32'h1234_5678);
        end
        wren = 1'b0;
        tick();
        tick();
        checks++;
        if (q[31:0] !== 32'h1234_5678) begin
            errors++; $display("FAIL raw_later: got %h expected %h", q[31:0], 32'h1234_5678);
        end
    endtask

    task automatic test_zero();
        wren = 1'b1; wraddress = 5'd0; data = 32'hFFFF_FFFF;
        sb_set = 1'b1; sb_addr = 5'd0;
        rdaddress = {5'd0, 5'd0};
        tick();
        idle();
        tick();
        checks++;
        if (q !== 64'd0) begin
            errors++; $display("FAIL zero_q: got %h expected %h", q, 64'd0);
        end
        checks++;
        if (busy !== 2'b00) begin
            errors++; $display("FAIL zero_busy: got %b expected %b", busy, 2'b00);
        end
    endtask

    task automatic test_hold();
        wren = 1'b1; wraddress = 5'd9; data = 32'h0000_0099;
        rdaddress = {5'd7, 5'd0};
        tick();
        wren = 1'b1; wraddress = 5'd7; data = 32'h0000_00A5;
        rd_clk_cls = 1'b1; rdaddress = {5'd9, 5'd9};
        tick();
        checks++;
        if (q[63:32] !== 32'h0000_00A5) begin
            errors++; $display("FAIL hold_forward: got %h expected %h", q[63:32], 32'h0000_00A5);
        end
        wren = 1'b0;
        tick();
        checks++;
        if (q[63:32] !== 32'h0000_00A5) begin
            errors++; $display("FAIL hold_bank: got %h expected %h", q[63:32], 32'h0000_00A5);
        end
        idle();
    endtask

    task automatic test_scoreboard();
        sb_set = 1'b1; sb_addr = 5'd5; rdaddress = {5'd0, 5'd5};
        tick();
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++; $display("FAIL sb_set_busy: got %b expected %b", busy[0], 1'b1);
        end
        sb_set = 1'b0; wren = 1'b1; wraddress = 5'd5; data = 32'h0000_0042;
        tick();
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++; $display("FAIL sb_clear_busy: got %b expected %b", busy[0], 1'b0);
        end
        checks++;
        if (q[31:0] !== 32'h0000_0042) begin
            errors++; $display("FAIL sb_clear_q: got %h expected %h", q[31:0], 32'h0000_0042);
        end
        idle();
    endtask

    task automatic test_set_wins_and_reset_write();
        sb_set = 1'b1; sb_addr = 5'd6;
        wren = 1'b1; wraddress = 5'd6; data = 32'h0000_0066;
        rdaddress = {5'd6, 5'd6};
        tick();
        checks++;
        if (busy !== 2'b11) begin
            errors++; $display("FAIL set_wins: got %b expected %b", busy, 2'b11);
        end
        sb_set = 1'b0; wren = 1'b1; wraddress = 5'd2; data = 32'h0000_2222;
        tick();
        idle();
        tick();
        rst = 1'b1; wren = 1'b1; wraddress = 5'd2; data = 32'h0000_DEAD;
        tick();
        idle();
        rdaddress = {5'd6, 5'd2};
        tick();
        checks++;
        if (q[31:0] !== 32'h0000_2222) begin
            errors++; $display("FAIL reset_write_lost: got %h expected %h", q[31:0], 32'h0000_2222);
        end
        checks++;
        if (busy !== 2'b00) begin
            errors++; $display("FAIL reset_busy_clear: got %b expected %b", busy, 2'b00);
        end
    endtask

    task automatic test_fill();
        for (int r = 1; r < 32; r++) begin
            wren = 1'b1; wraddress = r[4:0]; data = $urandom;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] exp_d;
        logic [4:0]  a;
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            wren       = ($urandom_range(0, 1) == 1);
            wraddress  = 5'($urandom_range(0, 31));
            data       = $urandom;
            rd_clk_cls = ($urandom_range(0, 3) == 0);
            sb_set     = ($urandom_range(0, 9) < 3);
            sb_addr    = ($urandom_range(0, 3) == 0) ? wraddress : 5'($urandom_range(0, 31));
            rdaddress[4:0] = ($urandom_range(0, 2) == 0) ? wraddress : 5'($urandom_range(0, 31));
            rdaddress[9:5] = ($urandom_range(0, 3) == 0) ? rdaddress[4:0] : 5'($urandom_range(0, 31));
            tick();
            for (int p = 0; p < 2; p++) begin
                a = m_addr[p];
                if ((a == 5'd0) || m_known[a]) begin
                    exp_d = (a == 5'd0) ? 32'd0 : m_mem[a];
                    checks++;
                    if (q[p*32 +: 32] !== exp_d) begin
                        errors++;
                        $display("FAIL rand_q%0d cycle %0d addr %0d: got %h expected %h", p, n, a, q[p*32 +: 32], exp_d);
                    end
                end
                checks++;
                if (busy[p] !== m_busy[a]) begin
                    errors++;
                    $display("FAIL rand_busy%0d cycle %0d addr %0d: got %b expected %b", p, n, a, busy[p], m_busy[a]);
                end
            end
        end
        idle();
    endtask

    task automatic test_wide();
        w_rst = 1'b0;
        w_wren = 1'b1; w_wraddress = 3'd4; w_data = 16'hBEEF;
        w_rdaddress = {4{3'd4}};
        tick();
        w_wren = 1'b0;
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (w_q[p*16 +: 16] !== 16'hBEEF) begin
                errors++; $display("FAIL wide_fwd_q%0d: got %h expected %h", p, w_q[p*16 +: 16], 16'hBEEF);
            end
        end
        tick();
        for (int p = 0; p < 4; p++) begin
            checks++;
            if (w_q[p*16 +: 16] !== 16'hBEEF) begin
                errors++; $display("FAIL wide_bank_q%0d: got %h expected %h", p, w_q[p*16 +: 16], 16'hBEEF);
            end
        end
        checks++;
        if (w_busy !== 4'b0000) begin
            errors++; $display("FAIL wide_busy: got %b expected %b", w_busy, 4'b0000);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_mem[r] = '0; m_known[r] = 1'b0; m_busy[r] = 1'b0;
        end
        m_addr[0] = '0; m_addr[1] = '0;
        @(negedge clock);
        test_reset();
        test_raw();
        test_zero();
        test_hold();
        test_scoreboard();
        test_set_wins_and_reset_write();
        test_fill();
        test_random();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
